req_ack_target: RTL
===================

Name: req_ack_target

Overview:
- Destination-side responder for the two-client req/ack bus arbiter.
- Consumes the arbiter's winner_req and winner_data_req. The data field carries {client_id, payload}.
- Executes a small command on a per-client accumulator, then returns a one-cycle winner_ack pulse with result data.
- Sits directly downstream of the arbiter as the bus endpoint.

Parameters:
- REQ_DATA_WIDTH, 8: request payload width. Must be >= 3. The request port is REQ_DATA_WIDTH+1 bits wide; its MSB is the client id.
- ACK_DATA_WIDTH, 8: width of the ack data, the accumulators and the transaction counters. Must be >= REQ_DATA_WIDTH-2.
- LATENCY, 2: number of clock edges from request capture to the ack rising edge. Must be >= 1.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- winner_req, input, 1: request from the arbiter. Held high until the ack is seen.
- winner_data_req, input, REQ_DATA_WIDTH+1: bit [REQ_DATA_WIDTH] is the client id (0/1). Bits [REQ_DATA_WIDTH-1:0] are the payload.
- winner_ack, output, 1: acknowledge, exactly one cycle high per transaction.
- winner_data_ack, output, ACK_DATA_WIDTH: result data, valid while winner_ack is high.
- busy, output, 1: high in every state except IDLE.
- prot_err, output, 1: sticky protocol error flag. Driven 0 when the macro is absent.

Behaviour:
- Reset (async, rst=1): state=IDLE; winner_ack=0; winner_data_ack=0; busy=0; prot_err=0; both accumulators=0; both counters=0; captured command cleared.
- Payload decode:
  - opcode = payload[REQ_DATA_WIDTH-1:REQ_DATA_WIDTH-2].
  - operand = payload[REQ_DATA_WIDTH-3:0], zero-extended to ACK_DATA_WIDTH.
- Opcodes, all applied to the accumulator and counter selected by the captured client id:
  - 00 READ: result = acc.
  - 01 ADD: acc <= acc+operand, modulo 2^ACK_DATA_WIDTH. Result = new acc.
  - 10 CLEAR: result = old acc; acc <= 0.
  - 11 COUNT: result = counter value after this transaction's increment.
- Counter:
  - Each completed transaction increments its client's counter, including COUNT itself.
  - Saturates at all-ones.
- FSM:
  - IDLE: if winner_req=1 at an edge, capture winner_data_req, load the latency counter and go to BUSY.
  - BUSY: decrement the latency counter. At the edge ending the LATENCY-th cycle after capture, execute the opcode, drive winner_data_ack=result and winner_ack=1, and go to ACK.
  - ACK: at the next edge winner_ack<=0 and winner_data_ack<=0. If winner_req=0, go to IDLE; otherwise go to WAIT_LOW.
  - WAIT_LOW: stay while winner_req=1. Go to IDLE on the first edge where winner_req=0. No new capture happens in this state.
- Timing: capture at edge E0; winner_ack is high between edges E0+LATENCY and E0+LATENCY+1. With LATENCY=1, ack rises on the edge after capture.
- Request data is sampled only at capture. Changes to it during BUSY are ignored.
- A new request is accepted no earlier than one cycle after winner_ack falls. This guarantees the arbiter never sees a stale ack for the next client.
- Reset mid-transaction: abort immediately. No ack is issued, and all state returns to reset values.

Optional Feature:
- Macro: REQ_ACK_TARGET_DROP_CHECK_EN.
- Defined: if winner_req=0 at any edge while in BUSY:
  - prot_err <= 1, sticky until reset.
  - The transaction is discarded: no ack, and no accumulator or counter update.
  - State goes to IDLE.
- Undefined: a dropped request in BUSY is ignored; the ack is still issued and the update still applies. prot_err is tied 0.

Test Plan:
1. Reset. Assert rst for 3 cycles, with winner_req=1 during reset, then release -> winner_ack=0, winner_data_ack=0, busy=0, prot_err=0. The first capture happens on the edge after release.
2. Client 0 ADD. LATENCY=2; winner_data_req=9'h045 (client 0, ADD 5) -> busy rises; ack is high exactly one cycle at E0+2 with data 8'h05. Then 9'h043 -> data 8'h08.
3. Client separation. Client 1 READ 9'h100 -> 8'h00. Then client 0 READ 9'h000 -> 8'h08.
4. Wrap-around. Client 1 ADD 63 (9'h17F) five times -> acks 63, 126, 189, 252, 59. Then CLEAR 9'h180 -> 59, followed by READ 9'h100 -> 0.
5. Counter and handshake hold. Client 0 COUNT 9'h0C0 after three prior client 0 transactions -> 8'h04. Hold winner_req high for 3 cycles after the ack -> FSM stays in WAIT_LOW with no second ack. After winner_req falls, busy falls one edge later.
6. Macro defined: drop winner_req one cycle after capture -> no ack, prot_err=1 and stays 1, accumulator unchanged. Macro undefined, same stimulus -> ack is issued with the result and prot_err=0.

Source files
------------

// File: rtl/req_ack_target.sv
// Bus endpoint behind the two-client req/ack arbiter: runs READ/ADD/CLEAR/COUNT on per-client state.
// Optional macro REQ_ACK_TARGET_DROP_CHECK_EN: a request dropped during BUSY aborts it and sets prot_err.
module req_ack_target #(
  parameter int REQ_DATA_WIDTH = 8,
  parameter int ACK_DATA_WIDTH = 8,
  parameter int LATENCY        = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      winner_req,
  input  logic [REQ_DATA_WIDTH:0]   winner_data_req,
  output logic                      winner_ack,
  output logic [ACK_DATA_WIDTH-1:0] winner_data_ack,
  output logic                      busy,
  output logic                      prot_err
);

  localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, ACK, WAIT_LOW} state_t;

  state_t                    state, state_d;
  logic [LW-1:0]             lat, lat_d;
  logic [REQ_DATA_WIDTH:0]   cmd, cmd_d;
  logic [ACK_DATA_WIDTH-1:0] acc [2];
  logic [ACK_DATA_WIDTH-1:0] acc_d [2];
  logic [ACK_DATA_WIDTH-1:0] cnt [2];
  logic [ACK_DATA_WIDTH-1:0] cnt_d [2];
  logic                      ack_d;
  logic [ACK_DATA_WIDTH-1:0] data_d;
  logic                      drop;
  logic                      cid;
  logic [1:0]                opcode;
  logic [ACK_DATA_WIDTH-1:0] operand;
  logic [ACK_DATA_WIDTH-1:0] cnt_inc;

`ifdef REQ_ACK_TARGET_DROP_CHECK_EN
  assign drop = ~winner_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      prot_err <= 1'b0;
    else if (state == BUSY && !winner_req)
      prot_err <= 1'b1;
  end
`else
  assign drop     = 1'b0;
  assign prot_err = 1'b0;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    cid     = cmd[REQ_DATA_WIDTH];
    opcode  = cmd[REQ_DATA_WIDTH-1:REQ_DATA_WIDTH-2];
    operand = '0;
    operand[REQ_DATA_WIDTH-3:0] = cmd[REQ_DATA_WIDTH-3:0];
    // Saturating increment; COUNT reports this post-increment value.
    cnt_inc = (cnt[cid] == '1) ? cnt[cid] : cnt[cid] + ACK_DATA_WIDTH'(1);
  end

  always_comb begin
    state_d = state;
    lat_d   = lat;
    cmd_d   = cmd;
    acc_d   = acc;
    cnt_d   = cnt;
    ack_d   = 1'b0;
    data_d  = '0;
    case (state)
      IDLE: begin
        if (winner_req) begin
          cmd_d   = winner_data_req;
          lat_d   = LW'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (drop) begin
          state_d = IDLE;
        end else if (lat != '0) begin
          lat_d = lat - LW'(1);
        end else begin
          cnt_d[cid] = cnt_inc;
          ack_d      = 1'b1;
          state_d    = ACK;
          case (opcode)
            2'b00: data_d = acc[cid];
            2'b01: begin
              acc_d[cid] = acc[cid] + operand;
              data_d     = acc[cid] + operand;
            end
            2'b10: begin
              data_d     = acc[cid];
              acc_d[cid] = '0;
            end
            default: data_d = cnt_inc;
          endcase
        end
      end
      ACK:      state_d = winner_req ? WAIT_LOW : IDLE;
      WAIT_LOW: if (!winner_req) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      lat             <= '0;
      cmd             <= '0;
      acc             <= '{'0, '0};
      cnt             <= '{'0, '0};
      winner_ack      <= 1'b0;
      winner_data_ack <= '0;
    end else begin
      state           <= state_d;
      lat             <= lat_d;
      cmd             <= cmd_d;
      acc             <= acc_d;
      cnt             <= cnt_d;
      winner_ack      <= ack_d;
      winner_data_ack <= data_d;
    end
  end

endmodule
